// File: rtl/prbs_chk_pkg.sv
// Shared types and helpers for the PRBS checker: FSM state, counter width,
// and the LFSR prediction function.
package prbs_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int unsigned CNT_W = 4;

    // Operands are zero-extended to 32 bits, so N is limited to 32.
    function automatic logic predict(input logic [31:0] mask, input logic [31:0] sr);
        return ^(mask & sr);
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear is applied before the
// increment, so a clear and a count on the same edge leave the value 1.
module prbs_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] base;
    logic [W-1:0] nxt;

    always_comb begin
        base = clr ? '0 : cnt;
        nxt  = base;
        if (inc && (base != '1)) begin
            nxt = base + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising Fibonacci-LFSR PRBS checker with lock, error pulse and
// saturating error count. Optional bit counter: define PRBS_CHK_BITCNT_EN.
module prbs_checker
    import prbs_chk_pkg::*;
#(
    parameter int unsigned   N           = 3,
    parameter logic [N-1:0]  TAPS        = 3'b110,
    parameter int unsigned   LOCK_CNT    = 4,
    parameter int unsigned   LOSS_THRESH = 3,
    parameter int unsigned   ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [ERR_W+7:0] bit_cnt
`endif
);

    chk_state_t       state, state_n;
    logic [N:1]       sr, sr_n;
    logic [CNT_W-1:0] load, load_n;
    logic [CNT_W-1:0] match, match_n;
    logic [CNT_W-1:0] miss, miss_n;
    logic             pred;
    logic             pulse_n;
    logic             err_inc;

    assign pred = predict(32'(TAPS), 32'(sr));

    always_comb begin
        state_n = state;
        sr_n    = sr;
        load_n  = load;
        match_n = match;
        miss_n  = miss;
        pulse_n = 1'b0;
        err_inc = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    sr_n = {sr[N-1:1], in_bit};
                    if (load == CNT_W'(N - 1)) begin
                        state_n = VERIFY;
                        load_n  = '0;
                        match_n = '0;
                    end else begin
                        load_n = load + CNT_W'(1);
                    end
                end
                VERIFY: begin
                    sr_n = {sr[N-1:1], in_bit};
                    if (in_bit != pred) begin
                        match_n = '0;
                    end else if (|sr) begin
                        // An all-zero register predicts zeros forever, so it never earns a match.
                        if (match == CNT_W'(LOCK_CNT - 1)) begin
                            state_n = LOCKED;
                            match_n = '0;
                            miss_n  = '0;
                        end else begin
                            match_n = match + CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    sr_n = {sr[N-1:1], pred};
                    if (in_bit != pred) begin
                        pulse_n = 1'b1;
                        err_inc = 1'b1;
                        if (miss == CNT_W'(LOSS_THRESH - 1)) begin
                            state_n = HUNT;
                            load_n  = '0;
                            match_n = '0;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss + CNT_W'(1);
                        end
                    end else begin
                        miss_n = '0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            sr        <= '0;
            load      <= '0;
            match     <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            load      <= load_n;
            match     <= match_n;
            miss      <= miss_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= pulse_n;
        end
    end

    prbs_sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (err_inc),
        .cnt (err_cnt)
    );

`ifdef PRBS_CHK_BITCNT_EN
    logic bit_inc;

    assign bit_inc = in_valid && (state == LOCKED);

    prbs_sat_counter #(.W(ERR_W + 8)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (bit_inc),
        .cnt (bit_cnt)
    );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a behavioural
// model of the HUNT/VERIFY/LOCKED rules, plus hand-computed milestones.
module tb_prbs_checker;

    localparam int N    = 3;
    localparam int TP   = 6;
    localparam int LCK  = 4;
    localparam int LOSS = 3;
    localparam int EW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [EW-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [EW+7:0] bit_cnt;
`endif

    prbs_checker #(
        .N           (N),
        .TAPS        (3'b110),
        .LOCK_CNT    (LCK),
        .LOSS_THRESH (LOSS),
        .ERR_W       (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = hunting, 1 = verifying, 2 = locked; h[1] is the newest bit.
    int  mode, loaded, streak, misses;
    int  h [N+1];
    int  m_err, m_bits, m_lk, m_pl;
    bit  armed = 1'b0;

    function automatic int model_pred();
        int p = 0;
        for (int i = 1; i <= N; i++)
            if (((TP >> (i - 1)) & 1) != 0) p ^= h[i];
        return p;
    endfunction

    function automatic void model_push(input int b);
        for (int i = N; i >= 2; i--) h[i] = h[i-1];
        h[1] = b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            mode = 0; loaded = 0; streak = 0; misses = 0;
            for (int i = 0; i <= N; i++) h[i] = 0;
            m_err = 0; m_bits = 0; m_lk = 0; m_pl = 0;
        end else if (armed) begin
            int p, nz;
            m_pl = 0;
            if (clr_cnt) begin
                m_err = 0;
                m_bits = 0;
            end
            if (in_valid) begin
                p  = model_pred();
                nz = 0;
                for (int i = 1; i <= N; i++) nz |= h[i];
                if (mode == 0) begin
                    model_push(int'(in_bit));
                    loaded++;
                    if (loaded == N) begin mode = 1; streak = 0; end
                end else if (mode == 1) begin
                    if (int'(in_bit) == p) begin
                        if (nz != 0) streak++;
                    end else streak = 0;
                    model_push(int'(in_bit));
                    if (streak == LCK) begin mode = 2; misses = 0; end
                end else begin
                    if (m_bits < (1 << (EW + 8)) - 1) m_bits++;
                    if (int'(in_bit) != p) begin
                        m_pl = 1;
                        if (m_err < (1 << EW) - 1) m_err++;
                        misses++;
                    end else misses = 0;
                    model_push(p);
                    if (misses == LOSS) begin
                        mode = 0; loaded = 0; streak = 0; misses = 0;
                    end
                end
            end
            m_lk = (mode == 2) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("locked", 32'(locked), m_lk);
            check("err_pulse", 32'(err_pulse), m_pl);
            check("err_cnt", 32'(err_cnt), m_err);
`ifdef PRBS_CHK_BITCNT_EN
            check("bit_cnt", 32'(bit_cnt), m_bits);
`endif
        end
    end

    // Default PRBS x^3+x^2+1 as emitted by the upstream stage.
    bit seq [7] = '{1, 0, 0, 1, 0, 1, 1};
    int ph = 0;

    function automatic bit nb();
        bit b = seq[ph];
        ph = (ph + 1) % 7;
        return b;
    endfunction

    task automatic cyc(input bit v, input bit b, input bit c);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit inv, input bit gap);
        if (gap && ($urandom_range(0, 2) == 0)) cyc(1'b0, 1'($urandom), 1'b0);
        cyc(1'b1, nb() ^ inv, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        ph = 0;
    endtask

    task automatic lock_seq(input bit gap, input string tag);
        for (int k = 1; k <= 7; k++) begin
            send(1'b0, gap);
            check(tag, 32'(locked), (k == 7) ? 1 : 0);
        end
    endtask

    initial begin
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_err", 32'(err_cnt), 0);

        lock_seq(1'b0, "lock");
        for (int k = 0; k < 50; k++) send(1'b0, 1'b0);
        check("clean_err", 32'(err_cnt), 0);

        send(1'b1, 1'b0);
        check("single_pulse", 32'(err_pulse), 1);
        check("single_err", 32'(err_cnt), 1);
        check("single_locked", 32'(locked), 1);
        send(1'b0, 1'b0);
        check("single_after", 32'(err_pulse), 0);
        for (int k = 0; k < 5; k++) send(1'b0, 1'b0);
        check("single_hold", 32'(err_cnt), 1);

        cyc(1'b0, 1'b0, 1'b1);
        check("clr_idle", 32'(err_cnt), 0);
        for (int k = 1; k <= 3; k++) begin
            send(1'b1, 1'b0);
            check("loss_pulse", 32'(err_pulse), 1);
            check("loss_locked", 32'(locked), (k == 3) ? 0 : 1);
        end
        check("loss_err", 32'(err_cnt), 3);
        lock_seq(1'b0, "relock");
        check("relock_err", 32'(err_cnt), 3);

        do_reset();
        lock_seq(1'b1, "stall_lock");

        do_reset();
        for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, 1'b0);
        check("zero_nolock", 32'(locked), 0);

        do_reset();
        lock_seq(1'b0, "cnt_lock");
        for (int k = 0; k < 20; k++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
            send(1'b0, 1'b0);
        end
        check("sat_err", 32'(err_cnt), 15);
        check("sat_locked", 32'(locked), 1);
        cyc(1'b1, nb() ^ 1'b1, 1'b1);
        check("clr_then_cnt", 32'(err_cnt), 1);
        check("clr_pulse", 32'(err_pulse), 1);

        send(1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, nb(), 1'b0);
        rst = 1'b0;
        check("midrst_locked", 32'(locked), 0);
        check("midrst_err", 32'(err_cnt), 0);
        check("midrst_pulse", 32'(err_pulse), 0);
        lock_seq(1'b0, "midrst_relock");

        for (int k = 0; k < 600; k++) begin
            bit v, inv, c;
            v   = ($urandom_range(0, 99) < 80);
            inv = ($urandom_range(0, 99) < 5);
            c   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if (v) cyc(1'b1, nb() ^ inv, c);
            else   cyc(1'b0, 1'($urandom), c);
            rst = 1'b0;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
